// File: rtl/scroll_pattern_gen.sv
// Scrolling tile-pattern generator: checkerboard / stripes / solid fill with a
// fixed-point 4-way scroll offset, frame-synchronous shadowed mode and palette.
module scroll_pattern_gen #(
    parameter int COORD_W   = 10,
    parameter int TILE_LOG2 = 5,
    parameter int FRAC_W    = 2,
    parameter int STEP_W    = 4,
    parameter int RGB_W     = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pattern_enable,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               active,
    input  logic               next_frame,
    input  logic [STEP_W-1:0]  step_size,
    input  logic [1:0]         dir,
    input  logic [1:0]         mode,
    input  logic [RGB_W-1:0]   color_a,
    input  logic [RGB_W-1:0]   color_b,
    output logic [RGB_W-1:0]   rgb
);

    localparam int ACC_W = COORD_W + FRAC_W;
    localparam logic [31:0] COLOR_A_RST32 = 32'd36;
    localparam logic [RGB_W-1:0] COLOR_A_RST = COLOR_A_RST32[RGB_W-1:0];

    logic [ACC_W-1:0]   x_acc_r;
    logic [ACC_W-1:0]   y_acc_r;
    logic [1:0]         mode_r;
    logic [RGB_W-1:0]   color_a_r;
    logic [RGB_W-1:0]   color_b_r;
    logic [RGB_W-1:0]   rgb_r;

    logic               frame_upd_s;
    logic [ACC_W-1:0]   step_ext_s;
    logic [COORD_W-1:0] sx_s;
    logic [COORD_W-1:0] sy_s;
    logic               tx_s;
    logic               ty_s;
    logic               sel_s;
    logic               unused_s;

    assign frame_upd_s = next_frame & pattern_enable;
    assign step_ext_s  = ACC_W'(step_size);

    // Per-frame scroll accumulators; only the axis named by dir moves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_acc_r <= {ACC_W{1'b0}};
            y_acc_r <= {ACC_W{1'b0}};
        end else if (frame_upd_s) begin
            case (dir)
                2'b00:   x_acc_r <= x_acc_r + step_ext_s;
                2'b01:   x_acc_r <= x_acc_r - step_ext_s;
                2'b10:   y_acc_r <= y_acc_r + step_ext_s;
                2'b11:   y_acc_r <= y_acc_r - step_ext_s;
                default: x_acc_r <= x_acc_r;
            endcase
        end
    end

    // Shadow registers so mode/palette changes only land on frame boundaries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r    <= 2'b00;
            color_a_r <= COLOR_A_RST;
            color_b_r <= {RGB_W{1'b0}};
        end else if (frame_upd_s) begin
            mode_r    <= mode;
            color_a_r <= color_a;
            color_b_r <= color_b;
        end
    end

    assign sx_s     = x + x_acc_r[ACC_W-1:FRAC_W];
    assign sy_s     = y + y_acc_r[ACC_W-1:FRAC_W];
    assign tx_s     = sx_s[TILE_LOG2];
    assign ty_s     = sy_s[TILE_LOG2];
    assign unused_s = ^{sx_s, sy_s};

    // Tile selection for the current pattern mode.
    always_comb begin
        sel_s = 1'b0;
        case (mode_r)
            2'b00:   sel_s = tx_s ^ ty_s;
            2'b01:   sel_s = tx_s;
            2'b10:   sel_s = ty_s;
            2'b11:   sel_s = 1'b1;
            default: sel_s = 1'b1;
        endcase
    end

    // Registered pixel colour, blanked outside the visible area.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_r <= {RGB_W{1'b0}};
        end else begin
            rgb_r <= active ? (sel_s ? color_a_r : color_b_r) : {RGB_W{1'b0}};
        end
    end

    assign rgb = rgb_r;

endmodule

// File: tb/tb_scroll_pattern_gen.sv
// Self-checking bench for scroll_pattern_gen: directed scenarios followed by
// randomized strobes and pixels, compared against an arithmetic reference model.
module tb_scroll_pattern_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pattern_enable = 1'b1;
    logic [9:0] x = 10'd0;
    logic [9:0] y = 10'd0;
    logic       active = 1'b1;
    logic       next_frame = 1'b0;
    logic [3:0] step_size = 4'd0;
    logic [1:0] dir = 2'd0;
    logic [1:0] mode = 2'd0;
    logic [5:0] color_a = 6'd36;
    logic [5:0] color_b = 6'd0;
    logic [5:0] rgb;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: offsets as quarter-pixel counts modulo 4096.
    int m_xq, m_yq, m_mode, m_ca, m_cb;

    scroll_pattern_gen dut (
        .clk(clk), .rst(rst), .pattern_enable(pattern_enable),
        .x(x), .y(y), .active(active), .next_frame(next_frame),
        .step_size(step_size), .dir(dir), .mode(mode),
        .color_a(color_a), .color_b(color_b), .rgb(rgb)
    );

    always #5 clk = ~clk;

    function automatic int exp_rgb(int px, int py, int act);
        int sx, sy, tx, ty, sel;
        sx = (px + m_xq / 4) % 1024;
        sy = (py + m_yq / 4) % 1024;
        tx = (sx / 32) % 2;
        ty = (sy / 32) % 2;
        case (m_mode)
            0:       sel = tx ^ ty;
            1:       sel = tx;
            2:       sel = ty;
            default: sel = 1;
        endcase
        if (act == 0) return 0;
        return sel != 0 ? m_ca : m_cb;
    endfunction

    task automatic model_reset();
        m_xq = 0; m_yq = 0; m_mode = 0; m_ca = 36; m_cb = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [5:0] obs, logic [5:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%02h expected=%02h", tag, obs, expv);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic pixel(int px, int py, logic act, string tag);
        logic [5:0] e;
        x = px[9:0]; y = py[9:0]; active = act;
        e = 6'(exp_rgb(px, py, int'(act)));
        tick();
        check(tag, rgb, e);
    endtask

    // One next_frame cycle; the pixel in that cycle must still use old state.
    task automatic strobe(logic en, int d, int st, string tag);
        logic [5:0] e;
        pattern_enable = en; next_frame = 1'b1;
        dir = d[1:0]; step_size = st[3:0];
        e = 6'(exp_rgb(int'(x), int'(y), int'(active)));
        tick();
        next_frame = 1'b0; pattern_enable = 1'b1;
        check(tag, rgb, e);
        if (en) begin
            case (d)
                0: m_xq = (m_xq + st) % 4096;
                1: m_xq = (m_xq - st + 4096) % 4096;
                2: m_yq = (m_yq + st) % 4096;
                default: m_yq = (m_yq - st + 4096) % 4096;
            endcase
            m_mode = int'(mode); m_ca = int'(color_a); m_cb = int'(color_b);
        end
    endtask

    initial begin
        model_reset();
        #2;
        check("reset_rgb", rgb, 6'd0);
        tick();
        do_reset();

        // Idle defaults
        pixel(0, 0, 1'b1, "idle_00");
        pixel(32, 0, 1'b1, "idle_32_0");
        pixel(32, 32, 1'b1, "idle_32_32");
        pixel(32, 0, 1'b0, "idle_inactive");

        // Integer scroll: 32 x 1.0 px right
        for (int i = 0; i < 32; i++) strobe(1'b1, 0, 4, "int_strobe");
        pixel(0, 0, 1'b1, "int_scroll_00");
        pixel(31, 0, 1'b1, "int_scroll_31");

        // Fractional scroll: integer offset only moves every 4th strobe
        do_reset();
        for (int i = 0; i < 4; i++) begin
            strobe(1'b1, 0, 1, "frac_strobe");
            pixel(31, 0, 1'b1, "frac_31");
        end
        for (int i = 0; i < 124; i++) strobe(1'b1, 0, 1, "frac_strobe");
        pixel(0, 0, 1'b1, "frac_128_00");

        // Reverse wrap
        do_reset();
        strobe(1'b1, 1, 4, "rev_strobe");
        pixel(1, 0, 1'b1, "rev_wrap_1");
        pixel(0, 0, 1'b1, "rev_wrap_0");

        // Vertical scroll up
        do_reset();
        strobe(1'b1, 3, 4, "vert_strobe");
        pixel(0, 0, 1'b1, "vert_00");
        pixel(0, 1, 1'b1, "vert_01");
        pixel(40, 1, 1'b1, "vert_40_1");

        // Shadowing: input changes invisible until the next strobe
        mode = 2'b01; color_b = 6'b000011;
        pixel(0, 1, 1'b1, "shadow_hold");
        pixel(0, 0, 1'b1, "shadow_hold2");
        strobe(1'b1, 0, 0, "shadow_strobe");
        pixel(0, 0, 1'b1, "shadow_loaded");
        pixel(32, 0, 1'b1, "shadow_loaded_a");

        // Gating: disabled strobes change nothing
        mode = 2'b10; color_a = 6'd7;
        strobe(1'b0, 0, 15, "gate_strobe");
        strobe(1'b0, 2, 15, "gate_strobe");
        pixel(0, 0, 1'b1, "gated_00");
        pixel(33, 0, 1'b1, "gated_33");

        // Asynchronous reset mid-cycle
        pixel(32, 0, 1'b1, "pre_async");
        #2 rst = 1'b1;
        #1 check("async_rst", rgb, 6'd0);
        #1 rst = 1'b0;
        model_reset();
        pixel(32, 0, 1'b1, "post_async");

        // Randomized strobes and pixels
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                mode    = 2'($urandom_range(0, 3));
                color_a = 6'($urandom_range(0, 63));
                color_b = 6'($urandom_range(0, 63));
                strobe($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 15)), "rand_strobe");
            end else begin
                pixel(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                      $urandom_range(0, 7) != 0, "rand_pixel");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
